// File: rtl/backend_stream_out_pkg.sv
// Shared definitions for the stream-out backend.
// Widths, output FSM states and the buffered beat bundle.
package backend_stream_out_pkg;

    localparam int DATA_W    = 256;
    localparam int ADDR_W    = 6;
    localparam int LEN_W     = 16;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int KEEP_SH   = $clog2(KEEP_W);
    localparam int MAX_BYTES = (2 ** ADDR_W) * KEEP_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } out_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    function automatic logic [LEN_W-1:0] sat_len(
        input logic [LEN_W-1:0] len
    );
        if (len > LEN_W'(MAX_BYTES)) begin
            return LEN_W'(MAX_BYTES);
        end
        return len;
    endfunction

    // A zero remainder means the last beat is full.
    function automatic logic [KEEP_W-1:0] last_keep(
        input logic [KEEP_SH-1:0] r
    );
        logic [KEEP_W-1:0] m;
        for (int i = 0; i < KEEP_W; i++) begin
            m[i] = (r == '0) || (i < int'(r));
        end
        return m;
    endfunction

endpackage

// File: rtl/backend_stream_out_axis_skid_buf.sv
// Small register FIFO holding {tdata, tkeep, tlast} beats.
// Head entry is stable until popped; occupancy feeds read credit.
module backend_stream_out_axis_skid_buf
    import backend_stream_out_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  beat_t            din,
    input  logic             pop,
    output beat_t            dout,
    output logic             valid,
    output logic [OCC_W-1:0] occupancy
);

    beat_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OCC_W-1:0] occ;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; caller never pushes when full.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign dout      = mem[rd_ptr];
    assign valid     = (occ != '0);
    assign occupancy = occ;

endmodule

// File: rtl/backend_stream_out.sv
// Reads a finished frame from the output BRAM and streams it out
// as 256-bit AXI-Stream beats, pulsing done after the tlast beat.
module backend_stream_out
    import backend_stream_out_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int CW    = OCC_W + 1;

    out_state_e        state_q;
    out_state_e        state_d;
    logic [LEN_W-1:0]  len_sat;
    logic [LEN_W-1:0]  nbeats_d;
    logic [KEEP_W-1:0] keep_d;
    logic [LEN_W-1:0]  nbeats_q;
    logic [KEEP_W-1:0] keep_last_q;
    logic [LEN_W-1:0]  iss_cnt;
    logic              iss_last;
    logic              rd_en;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic              pop;
    logic              credit_ok;
    logic [OCC_W-1:0]  occ;
    logic [CW-1:0]     used;
    beat_t             push_beat;
    beat_t             head;
    logic              head_valid;

    assign len_sat  = sat_len(length);
    assign nbeats_d = (len_sat + LEN_W'(KEEP_W - 1)) >> KEEP_SH;
    assign keep_d   = last_keep(len_sat[KEEP_SH-1:0]);

    // Read data lands one cycle after issue, so the only read in
    // flight at decision time is last cycle's; pop frees a slot now.
    assign pop       = head_valid && m_axis_tready;
    assign used      = CW'(occ) + CW'(rd_valid_q);
    assign credit_ok = used < (CW'(BUF_DEPTH) + CW'(pop));
    assign iss_last  = (iss_cnt == nbeats_q - 1'b1);
    assign rd_en     = (state_q == S_READ) && credit_ok;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len_sat == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_en && iss_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head.last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame setup, issue counter and read-return tracking.
    always_ff @(posedge aclk) begin
        if (areset) begin
            nbeats_q    <= '0;
            keep_last_q <= '0;
            iss_cnt     <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_last_q  <= rd_en && iss_last;
            if (state_q == S_IDLE && start) begin
                nbeats_q    <= nbeats_d;
                keep_last_q <= keep_d;
                iss_cnt     <= '0;
            end else if (rd_en) begin
                iss_cnt <= iss_cnt + 1'b1;
            end
        end
    end

    assign push_beat.data = bram_doutb;
    assign push_beat.keep = rd_last_q ? keep_last_q : '1;
    assign push_beat.last = rd_last_q;

    backend_stream_out_axis_skid_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .aclk      (aclk),
        .areset    (areset),
        .push      (rd_valid_q),
        .din       (push_beat),
        .pop       (pop),
        .dout      (head),
        .valid     (head_valid),
        .occupancy (occ)
    );

    assign bram_enb      = rd_en;
    assign bram_addrb    = iss_cnt[ADDR_W-1:0];
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign m_axis_tdata  = head.data;
    assign m_axis_tkeep  = head.keep;
    assign m_axis_tlast  = head.last;
    assign m_axis_tvalid = head_valid;

endmodule

// File: tb/tb_backend_stream_out.sv
// Scoreboard bench for backend_stream_out.
// BRAM model, negedge monitor, one task per scenario.
module tb_backend_stream_out;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } exp_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  length = '0;
    logic         busy;
    logic         done;
    logic         bram_enb;
    logic [5:0]   bram_addrb;
    logic [255:0] bram_doutb = '0;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;

    logic [255:0] mem [64];
    exp_t         exp_q[$];
    int           addr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int epoch = 0;
    int seen_epoch = 0;
    int start_cyc;

    int enb_cnt, first_enb_cyc, busy_cnt, busy_first;
    int done_cnt, done_cyc, first_valid_cyc, hs_cnt, last_hs_cyc;
    bit hold_pend = 1'b0;
    exp_t hold_b;

    backend_stream_out dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .bram_enb      (bram_enb),
        .bram_addrb    (bram_addrb),
        .bram_doutb    (bram_doutb),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        if (bram_enb && !areset) begin
            addr_q.push_back(int'(bram_addrb));
            bram_doutb <= mem[bram_addrb];
        end
    end

    always @(negedge aclk) begin
        exp_t e;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            enb_cnt = 0; first_enb_cyc = -1;
            busy_cnt = 0; busy_first = -1;
            done_cnt = 0; done_cyc = -1;
            first_valid_cyc = -1;
            hs_cnt = 0; last_hs_cyc = -1;
        end
        if (!areset) begin
            if (bram_enb) begin
                enb_cnt++;
                if (first_enb_cyc < 0) first_enb_cyc = cyc;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_axis_tvalid && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            if (hold_pend && m_axis_tvalid) begin
                checks++;
                if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast}
                    !== hold_b) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d keep=%h req %h",
                             cyc, m_axis_tkeep, hold_b.keep);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                checks++;
                if (m_axis_tlast) last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat cyc=%0d keep=%h",
                             cyc, m_axis_tkeep);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast}
                        !== e) begin
                        errors++;
                        $display("FAIL beat%0d keep=%h last=%b req keep=%h last=%b data_ok=%b",
                                 hs_cnt - 1, m_axis_tkeep, m_axis_tlast,
                                 e.keep, e.last, m_axis_tdata === e.data);
                    end
                end
            end
            hold_pend = m_axis_tvalid && !m_axis_tready;
            hold_b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_stats();
        epoch++;
        @(negedge aclk);
        tick();
    endtask

    task automatic push_frame(input int len);
        exp_t e;
        int l, nb, r;
        l = (len > 2048) ? 2048 : len;
        nb = (l + 31) / 32;
        r = l % 32;
        for (int i = 0; i < nb; i++) begin
            e.data = mem[i];
            e.last = (i == nb - 1);
            e.keep = 32'hFFFF_FFFF;
            if (e.last && r != 0) e.keep = 32'hFFFF_FFFF >> (32 - r);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_start(input int len);
        start = 1'b1;
        length = 16'(len);
        start_cyc = cyc;
        push_frame(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout waited=%0d req done within %0d",
                     n, budget);
        end
        repeat (4) tick();
    endtask

    task automatic check_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing left=%0d req 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy, done, bram_enb, bram_addrb, m_axis_tvalid,
             m_axis_tlast, m_axis_tkeep} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b enb=%b addr=%0d v=%b l=%b k=%h req 0",
                     busy, done, bram_enb, bram_addrb, m_axis_tvalid,
                     m_axis_tlast, m_axis_tkeep);
        end
        checks++;
        if (m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata got=%h req 0", m_axis_tdata);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_len64();
        m_axis_tready = 1'b1;
        clear_stats();
        send_start(64);
        wait_done(50);
        check_empty("len64");
        checks++;
        if (first_enb_cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL len64_enb_lat got=%0d req %0d",
                     first_enb_cyc, start_cyc + 1);
        end
        checks++;
        if (first_valid_cyc != start_cyc + 3) begin
            errors++;
            $display("FAIL len64_valid_lat got=%0d req %0d",
                     first_valid_cyc, start_cyc + 3);
        end
        checks++;
        if (done_cyc != start_cyc + 5 || last_hs_cyc != start_cyc + 4) begin
            errors++;
            $display("FAIL len64_done_cyc got=%0d/%0d req %0d/%0d",
                     last_hs_cyc, done_cyc, start_cyc + 4, start_cyc + 5);
        end
        checks++;
        if (hs_cnt != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL len64_counts beats=%0d dones=%0d req 2/1",
                     hs_cnt, done_cnt);
        end
    endtask

    task automatic test_len33();
        m_axis_tready = 1'b1;
        clear_stats();
        send_start(33);
        wait_done(50);
        check_empty("len33");
        checks++;
        if (hs_cnt != 2) begin
            errors++;
            $display("FAIL len33_beats got=%0d req 2", hs_cnt);
        end
    endtask

    task automatic test_back_to_back_toggle();
        int n = 0;
        clear_stats();
        addr_q.delete();
        send_start(2048);
        while (done_cnt == 0 && n < 400) begin
            m_axis_tready = ~m_axis_tready;
            tick();
            n++;
        end
        m_axis_tready = 1'b1;
        wait_done(50);
        check_empty("len2048");
        checks++;
        if (hs_cnt != 64 || addr_q.size() != 64) begin
            errors++;
            $display("FAIL len2048_counts beats=%0d reads=%0d req 64/64",
                     hs_cnt, addr_q.size());
        end
        for (int i = 0; i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[i] != i) begin
                errors++;
                $display("FAIL len2048_addr idx=%0d got=%0d req %0d",
                         i, addr_q[i], i);
            end
        end
    endtask

    task automatic test_len0();
        m_axis_tready = 1'b1;
        clear_stats();
        send_start(0);
        wait_done(20);
        repeat (5) tick();
        checks++;
        if (enb_cnt != 0 || first_valid_cyc != -1) begin
            errors++;
            $display("FAIL len0_activity enb=%0d valid_cyc=%0d req 0/-1",
                     enb_cnt, first_valid_cyc);
        end
        checks++;
        if (done_cyc != start_cyc + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL len0_done cyc=%0d cnt=%0d req %0d/1",
                     done_cyc, done_cnt, start_cyc + 1);
        end
        checks++;
        if (busy_cnt != 1 || busy_first != start_cyc + 1) begin
            errors++;
            $display("FAIL len0_busy cnt=%0d first=%0d req 1/%0d",
                     busy_cnt, busy_first, start_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d0;
        m_axis_tready = 1'b1;
        clear_stats();
        send_start(2048);
        while (hs_cnt < 10 && n < 200) begin
            tick();
            n++;
        end
        m_axis_tready = 1'b0;
        checks++;
        if (hs_cnt != 10) begin
            errors++;
            $display("FAIL mid_beats got=%0d req 10", hs_cnt);
        end
        tick();
        d0 = done_cnt;
        areset = 1'b1;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort tvalid=%b busy=%b req 0/0",
                     m_axis_tvalid, busy);
        end
        areset = 1'b0;
        exp_q.delete();
        repeat (10) tick();
        checks++;
        if (done_cnt != d0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done dones=%0d tvalid=%b req %0d/0",
                     done_cnt, m_axis_tvalid, d0);
        end
        m_axis_tready = 1'b1;
        clear_stats();
        send_start(32);
        wait_done(50);
        check_empty("after_reset");
        checks++;
        if (hs_cnt != 1) begin
            errors++;
            $display("FAIL after_reset_beats got=%0d req 1", hs_cnt);
        end
    endtask

    task automatic test_saturate();
        m_axis_tready = 1'b1;
        clear_stats();
        send_start(5000);
        repeat (5) tick();
        start = 1'b1;
        length = 16'd32;
        tick();
        start = 1'b0;
        wait_done(200);
        repeat (10) tick();
        check_empty("sat");
        checks++;
        if (hs_cnt != 64 || done_cnt != 1) begin
            errors++;
            $display("FAIL sat_counts beats=%0d dones=%0d req 64/1",
                     hs_cnt, done_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 8; j++) begin
                mem[i][32*j +: 32] = $urandom;
            end
        end
        #1;
        test_reset();
        test_len64();
        test_len33();
        test_back_to_back_toggle();
        test_len0();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
